// File: rtl/chipmunk_loader_pkg.sv
// Shared definitions for the chipmunk loader: host protocol bytes and the FSM encoding.
package chipmunk_loader_pkg;

    // Command bytes from the host
    localparam logic [7:0] CmdWrite = 8'h57;  // 'W'
    localparam logic [7:0] CmdRead  = 8'h52;  // 'R'
    localparam logic [7:0] CmdGo    = 8'h47;  // 'G'
    localparam logic [7:0] CmdAbort = 8'h58;  // 'X', only meaningful while the CPU runs

    // Reply bytes to the host
    localparam logic [7:0] RespAck     = 8'h06;
    localparam logic [7:0] RespDone    = 8'h44;
    localparam logic [7:0] RespAbort   = 8'h58;
    localparam logic [7:0] RespUnknown = 8'h3F;

    typedef enum logic [2:0] {
        StIdle,
        StArgHi,
        StArgLo,
        StCount,
        StWrite,
        StRead,
        StRun,
        StResp
    } loaderState_t;

    // Which command is collecting its arguments
    typedef enum logic [1:0] {
        OpWrite,
        OpRead,
        OpGo
    } loaderOp_t;

endpackage

// File: rtl/chipmunk_loader.sv
// Host-side loader and run controller for the chipmunk CPU. Owns the program RAM port,
// loads/reads it over a byte stream, and hands the port to the CPU while it runs.
module chipmunk_loader
    import chipmunk_loader_pkg::*;
#(
    parameter int unsigned addrSize = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          rxData,
    input  logic                rxValid,
    output logic                rxReady,
    output logic [7:0]          txData,
    output logic                txValid,
    input  logic                txReady,
    output logic [addrSize-1:0] memAddr,
    output logic [7:0]          memWrData,
    output logic                memWe_n,
    input  logic [7:0]          memRdData,
    input  logic [addrSize-1:0] cpuAddr,
    input  logic [7:0]          cpuWrData,
    input  logic                cpuWe_n,
    output logic [7:0]          cpuRdData,
    output logic                cpuReset_n,
    output logic [addrSize-1:0] cpuStartPC,
    input  logic                cpuDone
);

    localparam logic [addrSize-1:0] AddrOne = addrSize'(1);

    loaderState_t          stateQ, stateD;
    loaderOp_t             opQ, opD;
    logic [addrSize-1:0]   ptrQ, ptrD;
    logic [7:0]            countQ, countD;
    logic [addrSize-1:0]   addrQ, addrD;
    logic [7:0]            wrDataQ, wrDataD;
    logic                  weNQ, weND;
    logic [7:0]            txDataQ, txDataD;
    logic                  txValidQ, txValidD;
    logic                  cpuResetNQ, cpuResetND;
    logic [addrSize-1:0]   startPcQ, startPcD;
    logic                  rxAccept;

    // Gated by the reset input so the loader never claims a byte while held in reset
    assign rxReady  = reset && (stateQ != StRead) && (stateQ != StResp);
    assign rxAccept = rxValid && rxReady;

    assign txData     = txDataQ;
    assign txValid    = txValidQ;
    assign cpuReset_n = cpuResetNQ;
    assign cpuStartPC = startPcQ;
    assign cpuRdData  = memRdData;

    // RAM port mux: CPU owns the port combinationally in RUN, loader registers otherwise
    always_comb begin
        memAddr   = addrQ;
        memWrData = wrDataQ;
        memWe_n   = weNQ;
        if (stateQ == StRun) begin
            memAddr   = cpuAddr;
            memWrData = cpuWrData;
            memWe_n   = cpuWe_n;
        end
    end

    // Next-state logic for the command FSM and all loader registers
    always_comb begin
        stateD     = stateQ;
        opD        = opQ;
        ptrD       = ptrQ;
        countD     = countQ;
        addrD      = addrQ;
        wrDataD    = wrDataQ;
        weND       = 1'b1;  // write strobe lasts a single cycle
        txDataD    = txDataQ;
        txValidD   = txValidQ;
        cpuResetND = cpuResetNQ;
        startPcD   = startPcQ;

        case (stateQ)
            StIdle: begin
                if (rxAccept) begin
                    case (rxData)
                        CmdWrite: begin
                            opD    = OpWrite;
                            stateD = StArgHi;
                        end
                        CmdRead: begin
                            opD    = OpRead;
                            stateD = StArgHi;
                        end
                        CmdGo: begin
                            opD    = OpGo;
                            stateD = StArgHi;
                        end
                        default: begin
                            txDataD  = RespUnknown;
                            txValidD = 1'b1;
                            stateD   = StResp;
                        end
                    endcase
                end
            end

            StArgHi: begin
                if (rxAccept) begin
                    // Address bits above addrSize are dropped
                    ptrD   = {rxData[addrSize-9:0], 8'h00};
                    stateD = StArgLo;
                end
            end

            StArgLo: begin
                if (rxAccept) begin
                    ptrD = {ptrQ[addrSize-1:8], rxData};
                    if (opQ == OpGo) begin
                        // PC is presented now; CPU reset releases one cycle later
                        startPcD   = {ptrQ[addrSize-1:8], rxData};
                        cpuResetND = 1'b0;
                        stateD     = StRun;
                    end else begin
                        stateD = StCount;
                    end
                end
            end

            StCount: begin
                if (rxAccept) begin
                    countD = rxData;
                    if (opQ == OpWrite) begin
                        stateD = StWrite;
                    end else begin
                        addrD    = ptrQ;
                        txValidD = 1'b0;
                        stateD   = StRead;
                    end
                end
            end

            StWrite: begin
                if (rxAccept) begin
                    addrD   = ptrQ;
                    wrDataD = rxData;
                    weND    = 1'b0;
                    ptrD    = ptrQ + AddrOne;
                    if (countQ == 8'd0) begin
                        // Ack is raised by RESP once this final write strobe has gone by
                        txDataD  = RespAck;
                        txValidD = 1'b0;
                        stateD   = StResp;
                    end else begin
                        countD = countQ - 8'd1;
                    end
                end
            end

            StRead: begin
                if (!txValidQ) begin
                    txDataD  = memRdData;
                    txValidD = 1'b1;
                end else if (txReady) begin
                    txValidD = 1'b0;
                    if (countQ == 8'd0) begin
                        stateD = StIdle;
                    end else begin
                        addrD  = addrQ + AddrOne;
                        countD = countQ - 8'd1;
                    end
                end
            end

            StRun: begin
                // Done is ignored during the launch cycle while the CPU is still in reset
                if (cpuResetNQ && cpuDone) begin
                    cpuResetND = 1'b0;
                    txDataD    = RespDone;
                    txValidD   = 1'b1;
                    stateD     = StResp;
                end else if (rxAccept && (rxData == CmdAbort)) begin
                    cpuResetND = 1'b0;
                    txDataD    = RespAbort;
                    txValidD   = 1'b1;
                    stateD     = StResp;
                end else begin
                    cpuResetND = 1'b1;
                end
            end

            StResp: begin
                if (!txValidQ) begin
                    txValidD = 1'b1;
                end else if (txReady) begin
                    txValidD = 1'b0;
                    stateD   = StIdle;
                end
            end

            default: stateD = StIdle;
        endcase
    end

    // State registers; reset abandons any transfer and holds the CPU in reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ     <= StIdle;
            opQ        <= OpWrite;
            ptrQ       <= '0;
            countQ     <= 8'h00;
            addrQ      <= '0;
            wrDataQ    <= 8'h00;
            weNQ       <= 1'b1;
            txDataQ    <= 8'h00;
            txValidQ   <= 1'b0;
            cpuResetNQ <= 1'b0;
            startPcQ   <= '0;
        end else begin
            stateQ     <= stateD;
            opQ        <= opD;
            ptrQ       <= ptrD;
            countQ     <= countD;
            addrQ      <= addrD;
            wrDataQ    <= wrDataD;
            weNQ       <= weND;
            txDataQ    <= txDataD;
            txValidQ   <= txValidD;
            cpuResetNQ <= cpuResetND;
            startPcQ   <= startPcD;
        end
    end

endmodule

// File: tb/tb_chipmunk_loader.sv
// Self-checking bench for chipmunk_loader: behavioural RAM, scripted CPU stub and a
// byte-array reference model of the program memory.
module tb_chipmunk_loader;

    localparam int unsigned AddrSize = 12;
    localparam int          AddrSpan = 1 << AddrSize;

    logic                clk;
    logic                reset;
    logic [7:0]          rxData;
    logic                rxValid;
    logic                rxReady;
    logic [7:0]          txData;
    logic                txValid;
    logic                txReady;
    logic [AddrSize-1:0] memAddr;
    logic [7:0]          memWrData;
    logic                memWe_n;
    logic [7:0]          memRdData;
    logic [AddrSize-1:0] cpuAddr;
    logic [7:0]          cpuWrData;
    logic                cpuWe_n;
    logic [7:0]          cpuRdData;
    logic                cpuReset_n;
    logic [AddrSize-1:0] cpuStartPC;
    logic                cpuDone;

    int checks = 0;
    int errors = 0;
    int writeCount = 0;

    logic [7:0] ram    [AddrSpan];
    logic [7:0] refMem [AddrSpan];
    logic [7:0] wrBytes [$];

    chipmunk_loader #(
        .addrSize(AddrSize)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rxData     (rxData),
        .rxValid    (rxValid),
        .rxReady    (rxReady),
        .txData     (txData),
        .txValid    (txValid),
        .txReady    (txReady),
        .memAddr    (memAddr),
        .memWrData  (memWrData),
        .memWe_n    (memWe_n),
        .memRdData  (memRdData),
        .cpuAddr    (cpuAddr),
        .cpuWrData  (cpuWrData),
        .cpuWe_n    (cpuWe_n),
        .cpuRdData  (cpuRdData),
        .cpuReset_n (cpuReset_n),
        .cpuStartPC (cpuStartPC),
        .cpuDone    (cpuDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Async-read RAM with synchronous active-low write
    assign memRdData = ram[memAddr];
    always @(posedge clk) begin
        if (!memWe_n) begin
            ram[memAddr] <= memWrData;
            writeCount   <= writeCount + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int baseAddr(input logic [7:0] hi, input logic [7:0] lo);
        return ((int'(hi) * 256) + int'(lo)) % AddrSpan;
    endfunction

    task automatic sendByte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        rxData  = b;
        rxValid = 1'b1;
        while (!rxReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rxReady) begin
            check("rxReadyTimeout", 32'(rxReady), 32'd1);
            rxValid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 rxValid = 1'b0;
    endtask

    task automatic recvByte(output logic [7:0] b, input int stall);
        int n;
        logic [7:0] held;
        n = 0;
        @(negedge clk);
        while (!txValid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!txValid) begin
            check("txTimeout", 32'(txValid), 32'd1);
            b = 8'h00;
            return;
        end
        held = txData;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("txHold", {23'd0, txValid, txData}, {23'd0, 1'b1, held});
        end
        txReady = 1'b1;
        b = txData;
        @(posedge clk);
        #1 txReady = 1'b0;
    endtask

    // 'W' with the bytes queued in wrBytes; also checks strobe count and ack timing
    task automatic doWrite(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] n);
        int base;
        int wcStart;
        logic [7:0] b;
        base = baseAddr(hi, lo);
        sendByte(8'h57);
        sendByte(hi);
        sendByte(lo);
        sendByte(n);
        wcStart = writeCount;
        for (int i = 0; i <= int'(n); i++) begin
            sendByte(wrBytes[i]);
            refMem[(base + i) % AddrSpan] = wrBytes[i];
        end
        @(negedge clk);
        check("weLastByte", 32'(memWe_n), 32'd0);
        check("ackEarly", 32'(txValid), 32'd0);
        @(negedge clk);
        check("ackRise", 32'(txValid), 32'd1);
        check("wrCount", 32'(writeCount - wcStart), 32'(int'(n) + 1));
        recvByte(b, 0);
        check("ack", 32'(b), 32'h06);
    endtask

    task automatic doRead(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] n,
                          input int stall);
        int base;
        logic [7:0] b;
        base = baseAddr(hi, lo);
        sendByte(8'h52);
        sendByte(hi);
        sendByte(lo);
        sendByte(n);
        for (int i = 0; i <= int'(n); i++) begin
            recvByte(b, stall);
            check("rdData", 32'(b), 32'(refMem[(base + i) % AddrSpan]));
        end
    endtask

    // 'G': PC must be stable a cycle before CPU reset releases
    task automatic doGo(input logic [7:0] hi, input logic [7:0] lo);
        sendByte(8'h47);
        sendByte(hi);
        sendByte(lo);
        @(negedge clk);
        check("startPc", 32'(cpuStartPC), 32'(baseAddr(hi, lo)));
        check("cpuHeldAtLaunch", 32'(cpuReset_n), 32'd0);
        @(negedge clk);
        check("cpuReleased", 32'(cpuReset_n), 32'd1);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] n;
        int base;
        int txSeen;

        for (int i = 0; i < AddrSpan; i++) begin
            ram[i]    = 8'($urandom);
            refMem[i] = ram[i];
        end
        reset     = 1'b0;
        rxData    = 8'h00;
        rxValid   = 1'b0;
        txReady   = 1'b0;
        cpuAddr   = '0;
        cpuWrData = 8'h00;
        cpuWe_n   = 1'b1;
        cpuDone   = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rstRxReady", 32'(rxReady), 32'd0);
        check("rstTxValid", 32'(txValid), 32'd0);
        check("rstTxData", 32'(txData), 32'd0);
        check("rstMemWe", 32'(memWe_n), 32'd1);
        check("rstMemAddr", 32'(memAddr), 32'd0);
        check("rstMemWrData", 32'(memWrData), 32'd0);
        check("rstCpuReset", 32'(cpuReset_n), 32'd0);
        check("rstStartPc", 32'(cpuStartPC), 32'd0);
        reset = 1'b1;
        #1;
        check("rxReadyAfterRst", 32'(rxReady), 32'd1);

        // CPU write strobe must not reach RAM outside RUN
        @(negedge clk);
        cpuAddr = 12'h123;
        cpuWe_n = 1'b0;
        #1;
        check("cpuWeBlocked", 32'(memWe_n), 32'd1);
        @(negedge clk);
        cpuWe_n = 1'b1;

        // Directed write
        wrBytes = {8'hAA, 8'hBB, 8'hCC};
        doWrite(8'h00, 8'h10, 8'h02);
        check("ram010", 32'(ram[12'h010]), 32'hAA);
        check("ram011", 32'(ram[12'h011]), 32'hBB);
        check("ram012", 32'(ram[12'h012]), 32'hCC);

        // Wrap at top of memory, read back with a stalled host
        wrBytes = {8'h11, 8'h22};
        doWrite(8'h0F, 8'hFF, 8'h01);
        check("ramFFF", 32'(ram[12'hFFF]), 32'h11);
        check("ram000", 32'(ram[12'h000]), 32'h22);
        doRead(8'h0F, 8'hFF, 8'h01, 3);

        // Program image ending in halt; the stub CPU stores 5 at 0x080 then signals done
        wrBytes = {8'hA9, 8'h05, 8'h8D, 8'h80, 8'h00, 8'h83};
        doWrite(8'h01, 8'h00, 8'h05);
        doGo(8'h01, 8'h00);
        cpuAddr   = 12'h080;
        cpuWrData = 8'h05;
        cpuWe_n   = 1'b0;
        #1;
        check("runMemAddr", 32'(memAddr), 32'h080);
        check("runMemWe", 32'(memWe_n), 32'd0);
        check("runRdPass", 32'(cpuRdData), 32'(memRdData));
        refMem[12'h080] = 8'h05;
        @(negedge clk);
        cpuWe_n = 1'b1;
        cpuDone = 1'b1;
        @(posedge clk);
        #1 cpuDone = 1'b0;
        @(negedge clk);
        check("doneCpuReset", 32'(cpuReset_n), 32'd0);
        check("doneTxValid", 32'(txValid), 32'd1);
        recvByte(b, 0);
        check("doneReply", 32'(b), 32'h44);
        doRead(8'h00, 8'h80, 8'h00, 0);

        // Endless program: ignored byte, then abort
        doGo(8'h02, 8'h00);
        sendByte(8'h11);
        @(negedge clk);
        check("ignoreTx", 32'(txValid), 32'd0);
        check("ignoreRun", 32'(cpuReset_n), 32'd1);
        sendByte(8'h58);
        @(negedge clk);
        check("abortCpuReset", 32'(cpuReset_n), 32'd0);
        recvByte(b, 0);
        check("abortReply", 32'(b), 32'h58);

        // Done and abort in the same cycle: done wins, abort byte dropped
        doGo(8'h02, 8'h00);
        @(negedge clk);
        rxData  = 8'h58;
        rxValid = 1'b1;
        cpuDone = 1'b1;
        @(posedge clk);
        #1;
        rxValid = 1'b0;
        cpuDone = 1'b0;
        recvByte(b, 0);
        check("raceReply", 32'(b), 32'h44);
        txSeen = 0;
        repeat (6) begin
            @(negedge clk);
            if (txValid) txSeen++;
        end
        check("raceNoSecondReply", 32'(txSeen), 32'd0);

        // Unknown command
        sendByte(8'h00);
        recvByte(b, 0);
        check("unknownReply", 32'(b), 32'h3F);

        // Reset in the middle of a write: two data bytes land, the rest is abandoned
        sendByte(8'h57);
        sendByte(8'h00);
        sendByte(8'h20);
        sendByte(8'h05);
        sendByte(8'h5A);
        sendByte(8'hA5);
        refMem[12'h020] = 8'h5A;
        refMem[12'h021] = 8'hA5;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midRstMemWe", 32'(memWe_n), 32'd1);
        check("midRstTxValid", 32'(txValid), 32'd0);
        check("midRstCpuReset", 32'(cpuReset_n), 32'd0);
        check("midRstRxReady", 32'(rxReady), 32'd0);
        check("midRstStartPc", 32'(cpuStartPC), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        doRead(8'h00, 8'h20, 8'h05, 0);

        // Full 256-byte burst across the wrap point
        wrBytes = {};
        for (int i = 0; i < 256; i++) wrBytes.push_back(8'($urandom));
        doWrite(8'hFF, 8'h80, 8'hFF);
        doRead(8'h0F, 8'h80, 8'hFF, 0);

        // Randomized writes and reads against the reference memory
        for (int t = 0; t < 12; t++) begin
            hi = 8'($urandom);
            lo = 8'($urandom);
            n  = 8'($urandom_range(0, 20));
            wrBytes = {};
            for (int i = 0; i <= int'(n); i++) wrBytes.push_back(8'($urandom));
            doWrite(hi, lo, n);
            doRead(hi, lo, n, $urandom_range(0, 2));
            base = $urandom_range(0, AddrSpan - 1);
            doRead(8'(base >> 8), 8'(base), 8'($urandom_range(0, 10)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/chipmunk_loader.md
# chipmunk_loader

Host-side loader and run controller sitting directly upstream of the chipmunk CPU. It owns the shared program RAM port: a byte-stream command interface writes the program into RAM, launches the CPU at a chosen start PC, waits for the CPU's `done` (halt opcode 0x83), and reads RAM back. While the CPU runs, the RAM port is handed to the CPU unchanged.

## Interface
- addrSize, 12, RAM/CPU address width (9..16)

- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- rxData  in  8  command byte from host
- rxValid  in  1  rxData valid
- rxReady  out  1  loader accepts rxData this cycle
- txData  out  8  response byte to host
- txValid  out  1  txData valid
- txReady  in  1  host accepts txData
- memAddr  out  addrSize  RAM address (async-read RAM)
- memWrData  out  8  RAM write data
- memWe_n  out  1  RAM write enable, active-low
- memRdData  in  8  RAM read data, combinational from memAddr
- cpuAddr  in  addrSize  CPU addrBus
- cpuWrData  in  8  CPU dataBusWrite
- cpuWe_n  in  1  CPU weMem
- cpuRdData  out  8  CPU dataBus (= memRdData)
- cpuReset_n  out  1  CPU reset, active-low
- cpuStartPC  out  addrSize  CPU startPC
- cpuDone  in  1  CPU done

## Operation
- Accept: rxValid && rxReady at posedge. Send: txValid && txReady at posedge; txData/txValid held stable until accepted.
- States: IDLE, ARG_HI, ARG_LO, COUNT, WRITE, READ, RUN, RESP.
- Commands (first byte in IDLE):
  - 0x57 'W' addrHi addrLo n, then n+1 data bytes -> RAM; reply 0x06.
  - 0x52 'R' addrHi addrLo n -> send n+1 bytes from RAM.
  - 0x47 'G' pcHi pcLo -> run CPU; reply 0x44 on done, 0x58 on abort.
  - any other byte -> reply 0x3F, back to IDLE.
- Address = {addrHi[addrSize-9:0], addrLo}; upper addrHi bits ignored. Pointer increments per byte, wraps modulo 2^addrSize (0xFFF -> 0x000 at default).
- Byte count n is 8-bit; n=0 means 1 byte, n=0xFF means 256.
- rxReady = 1 in IDLE, ARG_HI, ARG_LO, COUNT, WRITE, RUN; 0 in READ, RESP.
- RUN: RAM port = CPU signals (memAddr=cpuAddr, memWrData=cpuWrData, memWe_n=cpuWe_n, passthrough combinational). Outside RUN, CPU-side writes are blocked (memWe_n from loader only).
- In RUN: cpuDone=1 -> end run, reply 0x44. Received 0x58 'X' -> abort, reply 0x58. Other bytes consumed, ignored. cpuDone and 'X' in same cycle: done wins, 'X' discarded.
- Ending a run: cpuReset_n low next cycle, then RESP.

## Timing
- Reset values: rxReady 0 during reset, txValid 0, txData 0x00, memWe_n 1, memAddr 0, memWrData 0, cpuReset_n 0, cpuStartPC 0, state IDLE. First cycle after reset release: rxReady 1.
- Write: data byte accepted at edge k -> memAddr/memWrData registered, memWe_n low for exactly cycle k+1; next data byte may be accepted at edge k+1.
- 0x06 is sent after the last write completes (txValid rises cycle k+2).
- Read: one cycle per byte minimum; txData registered from memRdData; next address presented cycle after each tx acceptance.
- Launch: pcLo accepted at edge k -> cpuStartPC valid cycle k+1, cpuReset_n high from cycle k+2 (PC stable ≥1 cycle before reset release).
- cpuDone sampled at edge m -> cpuReset_n low cycle m+1, txValid 0x44 cycle m+1.
- Reset mid-operation: immediate return to reset values; CPU held in reset; partial write/read abandoned.

## Structure
- Shared package chipmunk_loader_pkg: command bytes (0x57, 0x52, 0x47, 0x58), reply bytes (0x06, 0x44, 0x58, 0x3F), state encoding.
- No sub-module; RAM port mux inline, single FSM.

## Test plan
- 'W' 0x00 0x10 0x02 AA BB CC -> RAM[0x010..0x012]=AA,BB,CC, each memWe_n pulse 1 cycle; reply 0x06.
- 'W' 0x0F 0xFF 0x01 11 22 -> RAM[0xFFF]=11, RAM[0x000]=22 (wrap); then 'R' 0x0F 0xFF 0x01 -> tx 11,22, txReady stalled 3 cycles holds txData.
- Load program LDA #5 / STA $080 / 0x83 at 0x100, 'G' 0x01 0x00 -> cpuStartPC=0x100 one cycle before cpuReset_n=1; 0x44 after halt; 'R' 0x00 0x80 0x00 -> 0x05.
- Run infinite-loop program, send 'X' -> cpuReset_n low next cycle, reply 0x58; cpuDone and 'X' same cycle -> reply 0x44 only.
- Unknown byte 0x00 -> reply 0x3F; reset asserted mid-'W' -> memWe_n 1, txValid 0, cpuReset_n 0; next 'R' works normally.
